// File: rtl/guess_game_core.sv
// Number-guessing game engine: prompts via the handler write port, reads typed lines, scores guesses.
// Latency: an L-byte message takes L cycles with w_ready high; EV states last one cycle.
// Backpressure: idx only advances on fire, so a w_ready/r_ready stall holds address and data stable.
module guess_game_core #(
    parameter int DIGITS    = 2,
    parameter int MAX_TRIES = 7,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          term_ready,
    input  logic          w_ready,
    output logic          w_valid,
    output logic [7:0]    w_data,
    output logic [AW-1:0] w_addr,
    output logic          w_last,
    input  logic          r_ready,
    output logic          r_valid,
    output logic [AW-1:0] r_addr,
    input  logic [7:0]    r_data,
    input  logic          r_last,
    output logic          won,
    output logic          lost,
    output logic [7:0]    tries
);

    localparam int EW = 8 * DIGITS;
    localparam int CW = 3;
    localparam int IW = AW - 1;

    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS + 1);
    localparam logic [7:0]    EOF_B    = 8'hFF;
    localparam logic [7:0]    TRY_MAX  = 8'(MAX_TRIES);

    localparam logic [EW-1:0] ALL_ZERO = {DIGITS{8'h30}};
    localparam logic [EW-1:0] ALL_NINE = {DIGITS{8'h39}};

    localparam logic [8*12-1:0] S_NEW   = "Enter a code";
    localparam logic [8*7-1:0]  S_RANGE = "Range: ";
    localparam logic [8*9-1:0]  S_HIT   = "Cracked: ";
    localparam logic [8*8-1:0]  S_LOSE  = "Failed: ";

    // Message lengths including the trailing EOF byte.
    localparam int L_NEW   = 13;
    localparam int L_RANGE = 2 * DIGITS + 9;
    localparam int L_HIT   = DIGITS + 11;
    localparam int L_LOSE  = DIGITS + 9;

    typedef enum logic [3:0] {
        IDLE,
        W_NEW,
        R_CODE,
        EV_CODE,
        W_RANGE,
        R_GUESS,
        EV_GUESS,
        W_HIT,
        W_LOSE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic              rd_pend;
    logic [EW-1:0]     entry;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     code;
    logic [EW-1:0]     lower;
    logic [EW-1:0]     upper;
    logic [7:0]        tries_q;

    logic              w_fire;
    logic              r_fire;
    logic              in_read;
    logic              cap;
    logic              cap_eof;
    logic              legal;
    logic [7:0]        tries_inc;
    logic [EW+7:0]     shifted;
    logic              entering;
    int                k;
    int                msg_len;

    // Character j of a DIGITS-wide value, first-typed character at j = 0 (MSB byte).
    function automatic logic [7:0] dchar(input logic [EW-1:0] v, input int j);
        return v[8*(DIGITS-1-j) +: 8];
    endfunction

    assign w_fire    = w_valid & w_ready;
    assign r_fire    = r_valid & r_ready;
    assign in_read   = (state == R_CODE) || (state == R_GUESS);
    assign cap       = in_read & rd_pend;
    assign cap_eof   = cap & ((r_data == EOF_B) | r_last);
    assign tries_inc = (tries_q == 8'hFF) ? 8'hFF : tries_q + 8'd1;
    assign shifted   = {entry, r_data};
    assign entering  = (state_nxt != state);
    assign tries     = tries_q;

    // An entry is legal only with exactly DIGITS characters, all decimal digits.
    always_comb begin
        legal = (cnt == CNT_FULL);
        for (int i = 0; i < DIGITS; i++) begin
            if (entry[8*i +: 8] < 8'h30 || entry[8*i +: 8] > 8'h39) begin
                legal = 1'b0;
            end
        end
    end

    // Byte generator for the active message, indexed by idx.
    always_comb begin
        k       = int'(idx);
        msg_len = 0;
        w_valid = 1'b0;
        w_data  = EOF_B;
        w_addr  = '0;
        w_last  = 1'b0;
        case (state)
            W_NEW: begin
                w_valid = 1'b1;
                msg_len = L_NEW;
                if (k < 12) w_data = S_NEW[8*(11-k) +: 8];
            end
            W_RANGE: begin
                w_valid = 1'b1;
                msg_len = L_RANGE;
                if (k < 7)                      w_data = S_RANGE[8*(6-k) +: 8];
                else if (k < 7 + DIGITS)        w_data = dchar(lower, k - 7);
                else if (k == 7 + DIGITS)       w_data = 8'h7E;
                else if (k < 8 + 2 * DIGITS)    w_data = dchar(upper, k - 8 - DIGITS);
            end
            W_HIT: begin
                w_valid = 1'b1;
                msg_len = L_HIT;
                if (k < 9)                      w_data = S_HIT[8*(8-k) +: 8];
                else if (k < 9 + DIGITS)        w_data = dchar(code, k - 9);
                else if (k == 9 + DIGITS)       w_data = 8'h21;
            end
            W_LOSE: begin
                w_valid = 1'b1;
                msg_len = L_LOSE;
                if (k < 8)                      w_data = S_LOSE[8*(7-k) +: 8];
                else if (k < 8 + DIGITS)        w_data = dchar(code, k - 8);
            end
            default: ;
        endcase
        if (w_valid) begin
            w_addr = {1'b1, idx};
            w_last = (k == msg_len - 1);
        end
    end

    // Read requests stay up for the whole read state; late responses after EOF are ignored.
    always_comb begin
        r_valid = in_read;
        r_addr  = '0;
        if (in_read) r_addr = {1'b0, idx};
    end

    // Next-state and status pulses; won takes priority over running out of tries.
    always_comb begin
        state_nxt = state;
        won       = 1'b0;
        lost      = 1'b0;
        case (state)
            IDLE:     if (term_ready) state_nxt = W_NEW;
            W_NEW:    if (w_fire && w_last) state_nxt = R_CODE;
            R_CODE:   if (cap_eof) state_nxt = EV_CODE;
            EV_CODE:  state_nxt = legal ? W_RANGE : W_NEW;
            W_RANGE:  if (w_fire && w_last) state_nxt = R_GUESS;
            R_GUESS:  if (cap_eof) state_nxt = EV_GUESS;
            EV_GUESS: begin
                if (!legal) begin
                    state_nxt = W_RANGE;
                end else if (entry == code) begin
                    won       = 1'b1;
                    state_nxt = W_HIT;
                end else if (MAX_TRIES != 0 && tries_inc == TRY_MAX) begin
                    lost      = 1'b1;
                    state_nxt = W_LOSE;
                end else begin
                    state_nxt = W_RANGE;
                end
            end
            W_HIT:    if (w_fire && w_last) state_nxt = W_NEW;
            W_LOSE:   if (w_fire && w_last) state_nxt = W_NEW;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Byte index, read pipeline flag and line capture; index restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            rd_pend <= 1'b0;
            entry   <= '0;
            cnt     <= '0;
        end else begin
            rd_pend <= r_fire;
            if (entering)                idx <= '0;
            else if (w_fire || r_fire)   idx <= idx + IDX_ONE;

            if (entering && (state_nxt == R_CODE || state_nxt == R_GUESS)) begin
                entry <= '0;
                cnt   <= '0;
            end else if (cap && !cap_eof) begin
                entry <= shifted[EW-1:0];
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Game registers: code, bracketing range and try count.
    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= ALL_ZERO;
            lower   <= ALL_ZERO;
            upper   <= ALL_NINE;
            tries_q <= '0;
        end else if (state == EV_CODE && legal) begin
            code    <= entry;
            lower   <= ALL_ZERO;
            upper   <= ALL_NINE;
            tries_q <= '0;
        end else if (state == EV_GUESS && legal) begin
            tries_q <= tries_inc;
            if (state_nxt == W_RANGE) begin
                if (entry < code && entry > lower) lower <= entry;
                if (entry > code && entry < upper) upper <= entry;
            end
        end
    end

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core (DIGITS=2, MAX_TRIES=3) with a line-buffer read responder.
// Table of typed lines vs expected reply messages, plus reset, timing, stall and mid-message reset cases.
// Write port is observed on the falling edge; stimulus changes just after the rising edge.
module tb_guess_game_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       term_ready;
    logic       w_ready = 1'b1;
    logic       w_valid;
    logic [7:0] w_data;
    logic [7:0] w_addr;
    logic       w_last;
    logic       r_ready;
    logic       r_valid;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_last;
    logic       won;
    logic       lost;
    logic [7:0] tries;

    guess_game_core #(.DIGITS(2), .MAX_TRIES(3), .AW(8)) dut (
        .clk(clk), .rst(rst), .term_ready(term_ready),
        .w_ready(w_ready), .w_valid(w_valid), .w_data(w_data), .w_addr(w_addr), .w_last(w_last),
        .r_ready(r_ready), .r_valid(r_valid), .r_addr(r_addr), .r_data(r_data), .r_last(r_last),
        .won(won), .lost(lost), .tries(tries)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] line_buf [0:127];
    logic [7:0] wq_dat[$];
    logic [7:0] wq_adr[$];
    logic       wq_lst[$];
    int         wq_cyc[$];
    int         cyc = 0;
    int         rfire0_cyc = 0;
    int         won_cnt = 0;
    int         lost_cnt = 0;
    bit         wr_rand = 1'b0;

    typedef struct packed {
        logic [31:0]  line;
        logic [7:0]   line_len;
        logic [127:0] msg;
        logic [7:0]   msg_len;
        logic         then_new;
        logic [7:0]   tries;
        logic         won;
        logic         lost;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic type_line(input logic [31:0] s, input int n);
        for (int i = 0; i < 128; i++) line_buf[i] = 8'hFF;
        for (int i = 0; i < n; i++) line_buf[i] = s[8*(n-1-i) +: 8];
    endtask

    // Collect one message (up to the w_last byte) and compare text, length, addresses and EOF.
    task automatic expect_msg(input string name, input logic [127:0] exp, input int n,
                              output int span, output int first);
        logic [127:0] got;
        logic [7:0]   d;
        logic [7:0]   a;
        logic         l;
        int           c;
        int           nb;
        int           waited;
        bit           ok;
        bit           done;
        got = '0; nb = 0; waited = 0; ok = 1'b1; done = 1'b0; span = -1; first = -1;
        while (!done && waited < 3000) begin
            @(posedge clk); #2;
            waited++;
            while (wq_dat.size() > 0 && !done) begin
                d = wq_dat.pop_front();
                a = wq_adr.pop_front();
                l = wq_lst.pop_front();
                c = wq_cyc.pop_front();
                if (nb == 0) first = c;
                if (a !== 8'(128 + nb)) ok = 1'b0;
                if (l) begin
                    done = 1'b1;
                    span = c - first;
                    if (d !== 8'hFF) ok = 1'b0;
                end else begin
                    got = (got << 8) | {120'd0, d};
                end
                nb++;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no EOF byte after %0d cycles, got %0d bytes", name, waited, nb);
        end
        check({name, " text"}, got, exp);
        check({name, " length"}, nb, n + 1);
        check({name, " addr/eof"}, ok, 1'b1);
    endtask

    // Write-port monitor and stall stability check.
    initial begin
        bit         st_prev;
        logic [7:0] pd;
        logic [7:0] pa;
        st_prev = 1'b0; pd = '0; pa = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (st_prev && w_valid) begin
                check("stall data", w_data, pd);
                check("stall addr", w_addr, pa);
            end
            st_prev = w_valid && !w_ready;
            pd = w_data;
            pa = w_addr;
            if (w_valid && w_ready) begin
                wq_dat.push_back(w_data);
                wq_adr.push_back(w_addr);
                wq_lst.push_back(w_last);
                wq_cyc.push_back(cyc);
            end
            if (r_valid && r_ready && r_addr == 8'h00) rfire0_cyc = cyc;
            if (won) won_cnt++;
            if (lost) lost_cnt++;
        end
    end

    // Handler read model: data for a fired request appears in the following cycle.
    initial begin
        bit         rq;
        logic [6:0] ra;
        r_data = 8'h00;
        r_last = 1'b0;
        forever begin
            @(negedge clk);
            rq = r_valid && r_ready;
            ra = r_addr[6:0];
            @(posedge clk); #1;
            if (rq) begin
                r_data = line_buf[ra];
                r_last = (line_buf[ra] == 8'hFF);
            end else begin
                r_data = 8'h00;
                r_last = 1'b0;
            end
        end
    end

    // w_ready driver: held high, or random when wr_rand is set.
    initial begin
        forever begin
            @(posedge clk); #1;
            w_ready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int span;
        int first;
        int w0;
        int l0;
        int waited;
        bit found;

        rst = 1'b1; term_ready = 1'b0; r_ready = 1'b1;

        vecs[0]  = '{"42",  8'd2, "Range: 00~99", 8'd12, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1]  = '{"17",  8'd2, "Range: 17~99", 8'd12, 1'b0, 8'd1, 1'b0, 1'b0};
        vecs[2]  = '{"60",  8'd2, "Range: 17~60", 8'd12, 1'b0, 8'd2, 1'b0, 1'b0};
        vecs[3]  = '{"x5",  8'd2, "Range: 17~60", 8'd12, 1'b0, 8'd2, 1'b0, 1'b0};
        vecs[4]  = '{32'h0, 8'd0, "Range: 17~60", 8'd12, 1'b0, 8'd2, 1'b0, 1'b0};
        vecs[5]  = '{"42",  8'd2, "Cracked: 42!", 8'd12, 1'b1, 8'd3, 1'b1, 1'b0};
        vecs[6]  = '{"4a",  8'd2, "Enter a code", 8'd12, 1'b0, 8'd3, 1'b0, 1'b0};
        vecs[7]  = '{"123", 8'd3, "Enter a code", 8'd12, 1'b0, 8'd3, 1'b0, 1'b0};
        vecs[8]  = '{"50",  8'd2, "Range: 00~99", 8'd12, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[9]  = '{"10",  8'd2, "Range: 10~99", 8'd12, 1'b0, 8'd1, 1'b0, 1'b0};
        vecs[10] = '{"05",  8'd2, "Range: 10~99", 8'd12, 1'b0, 8'd2, 1'b0, 1'b0};
        vecs[11] = '{"30",  8'd2, "Failed: 50",   8'd10, 1'b1, 8'd3, 1'b0, 1'b1};
        type_line(32'h0, 0);

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst w_valid", w_valid, 1'b0);
        check("rst w_last", w_last, 1'b0);
        check("rst w_data", w_data, 8'hFF);
        check("rst w_addr", w_addr, 8'h00);
        check("rst r_valid", r_valid, 1'b0);
        check("rst r_addr", r_addr, 8'h00);
        check("rst won", won, 1'b0);
        check("rst lost", lost, 1'b0);
        check("rst tries", tries, 8'd0);

        // IDLE holds while the handler is not ready.
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle wait w_valid", w_valid, 1'b0);

        // Prompt; term_ready drops once the game has started and must be ignored.
        @(posedge clk); #1 term_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 term_ready = 1'b0;
        expect_msg("prompt", "Enter a code", 12, span, first);
        check("prompt cycles", span, 12);

        for (int i = 0; i < NV; i++) begin
            w0 = won_cnt;
            l0 = lost_cnt;
            type_line(vecs[i].line, int'(vecs[i].line_len));
            expect_msg($sformatf("v%0d", i), vecs[i].msg, int'(vecs[i].msg_len), span, first);
            if (vecs[i].then_new)
                expect_msg($sformatf("v%0d prompt", i), "Enter a code", 12, span, first);
            check($sformatf("v%0d tries", i), tries, vecs[i].tries);
            check($sformatf("v%0d won pulses", i), won_cnt - w0, vecs[i].won);
            check($sformatf("v%0d lost pulses", i), lost_cnt - l0, vecs[i].lost);
        end

        // Range message under random w_ready must be byte-identical.
        wr_rand = 1'b1;
        type_line("42", 2);
        expect_msg("rand range", "Range: 00~99", 12, span, first);
        wr_rand = 1'b0;

        // Empty guess: capture, EV, then first W_RANGE byte three cycles after the request.
        type_line(32'h0, 0);
        expect_msg("empty guess", "Range: 00~99", 12, span, first);
        check("eof latency", first - rfire0_cyc, 3);
        check("empty tries", tries, 8'd0);

        // Reset in the middle of W_RANGE.
        type_line("17", 2);
        waited = 0;
        found = 1'b0;
        while (!found && waited < 500) begin
            @(posedge clk); #2;
            waited++;
            if (w_valid && w_addr == 8'h84) found = 1'b1;
        end
        check("reach mid range", found, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst w_valid", w_valid, 1'b0);
        check("midrst r_valid", r_valid, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst idle", w_valid, 1'b0);
        check("midrst tries", tries, 8'd0);
        wq_dat.delete();
        wq_adr.delete();
        wq_lst.delete();
        wq_cyc.delete();
        @(posedge clk); #1 term_ready = 1'b1;
        expect_msg("prompt after rst", "Enter a code", 12, span, first);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/guess_game_core.md
# guess_game_core

Parametrised number-guessing game engine that drives the UART terminal handler's message write port and line read port. It supports DIGITS-digit codes, a configurable try limit with a lose path, and strict input validation. It sits between `uart_terminal_handler` and the board top, and adds `won`/`lost` status pulses and a try counter for LEDs.

## Interface
- DIGITS, 2: code length in decimal characters, legal 1..4.
- MAX_TRIES, 7: legal guesses allowed per game, 1..255; 0 means unlimited.
- AW, 8: handler buffer address width.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- term_ready  in  1  handler finished its own reset; level.
- w_ready  in  1  handler accepts a write byte.
- w_valid  out  1  write byte valid.
- w_data  out  8  write byte (ASCII, 8'hFF = EOF).
- w_addr  out  AW  write address, {1'b1, idx}.
- w_last  out  1  current write byte is the EOF.
- r_ready  in  1  handler accepts a read request.
- r_valid  out  1  read request valid.
- r_addr  out  AW  read address, {1'b0, idx}.
- r_data  in  8  read byte, valid the cycle after request fire.
- r_last  in  1  handler marks end of typed line; treated as EOF.
- won  out  1  one-cycle pulse on correct guess.
- lost  out  1  one-cycle pulse on try exhaustion.
- tries  out  8  legal guesses in current game.

## Operation
- States: IDLE, W_NEW, R_CODE, EV_CODE, W_RANGE, R_GUESS, EV_GUESS, W_HIT, W_LOSE.
- IDLE -> W_NEW when term_ready=1. idx counter cleared on every state entry.
- Write states: w_valid=1 constantly. A byte fires on w_valid&w_ready, then idx advances. The state is left on the fire of the EOF byte (w_last=1).
  - W_NEW sends "Enter a code", EOF (13 bytes).
  - W_RANGE sends "Range: ", lower[DIGITS], "~", upper[DIGITS], EOF.
  - W_HIT sends "Cracked: ", code, "!", EOF.
  - W_LOSE sends "Failed: ", code, EOF.
- Read states: r_valid=1 until the EOF byte arrives. The request fires on r_valid&r_ready and idx advances. On the cycle after the fire, r_data is captured:
  - Non-EOF byte: shifted into the DIGITS-byte entry register (newest in LSB position) and the char count increments, saturating at DIGITS+1.
  - EOF or r_last: enters the EV_ state and r_valid drops.
- Legal entry: char count == DIGITS and every byte is in 8'h30..8'h39. More characters than DIGITS is illegal.
- EV_CODE:
  - Legal: code <= entry; lower <= all "0"; upper <= all "9"; tries <= 0; -> W_RANGE.
  - Illegal: -> W_NEW.
- EV_GUESS: compare entry vs code as unsigned 8*DIGITS-bit vectors.
  - Illegal entry: tries unchanged; -> W_RANGE.
  - Legal entry: tries+1 (saturating at 255).
    - Equal: won pulse; -> W_HIT.
    - Otherwise, if tries+1 == MAX_TRIES (MAX_TRIES≠0): lost pulse; -> W_LOSE.
    - Otherwise: if entry<code and entry>lower, lower<=entry; if entry>code and entry<upper, upper<=entry. Guesses outside the range consume a try without narrowing. -> W_RANGE.
- W_HIT / W_LOSE -> W_NEW after EOF fire.
- Entry register and char count clear on entry to R_CODE/R_GUESS.

## Timing
- Reset values: w_valid=0, w_last=0, w_data=8'hFF, w_addr=0, r_valid=0, r_addr=0, won=0, lost=0, tries=0, state IDLE, lower all "0", upper all "9", code all "0".
- rst mid-message: w_valid/r_valid are low the cycle after rst is sampled. Any outstanding read response is discarded.
- Message of L bytes with w_ready held high takes exactly L cycles. A w_ready stall holds w_data/w_addr stable.
- EV_ states last exactly 1 cycle. won/lost assert in the EV_GUESS cycle.
- EOF response to W_RANGE first byte: 3 cycles (capture, EV, W_RANGE with w_valid=1).
- r_last and an EOF byte in the same cycle count once.
- term_ready dropping outside IDLE is ignored.

## Test plan
- Reset, term_ready=1, w_ready=1 -> "Enter a code"+FF written at addrs 0x80..0x8C in 13 cycles, w_last only on 0x8C.
- Code "42"+EOF, guess "17"+EOF -> Range " 00~99" first, then "Range: 17~99", tries=1.
- Guesses "60", then "42" -> "Range: 17~60", then won pulse, "Cracked: 42!", return to W_NEW, tries reset on next code.
- Code "4a", then "123" (DIGITS=2) -> W_NEW resent each time; guess "x5" in R_GUESS -> tries unchanged, range resent.
- MAX_TRIES=3, code "50", guesses "10","20","30" -> lost pulse on third, "Failed: 50"+FF.
- w_ready toggled randomly during W_RANGE -> byte stream identical to the w_ready=1 case; rst asserted mid-W_RANGE -> w_valid=0 next cycle, IDLE.
